// File: rtl/temp_uart_if.sv
// Sensor-side bundle for temp_uart_tx: update toggle and captured ASCII string in,
// serial line and status out.
interface temp_uart_if;
  logic             update_temp;
  logic [15:0][7:0] capt_temp;
  logic             uart_tx;
  logic             busy;
  logic             overrun;

  modport master (
    output update_temp, capt_temp,
    input  uart_tx, busy, overrun
  );

  modport slave (
    input  update_temp, capt_temp,
    output uart_tx, busy, overrun
  );
endinterface

// File: rtl/temp_uart_tx.sv
// Captures a 16-character temperature string on each update_temp toggle and sends it as 8N1.
// Optional macro TEMP_UART_CRLF_EN appends CR LF after every string (18 frames instead of 16).
module temp_uart_tx #(
  parameter int CLK_PER  = 10,
  parameter int BAUD     = 115200,
  parameter int BIT_CLKS = (1_000_000_000 + CLK_PER*BAUD/2) / (CLK_PER*BAUD)
) (
  input  logic        clk,
  input  logic        rst_n,
  temp_uart_if.slave  bus
);

  localparam int              TMR_W    = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BIT_CLKS - 1);
`ifdef TEMP_UART_CRLF_EN
  localparam logic [4:0]      CHAR_LAST = 5'd17;
`else
  localparam logic [4:0]      CHAR_LAST = 5'd15;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e           state_q,    state_d;
  logic [TMR_W-1:0] timer_q,    timer_d;
  logic [2:0]       bit_idx_q,  bit_idx_d;
  logic [4:0]       char_idx_q, char_idx_d;
  logic             tx_q,       tx_d;
  logic             pending_q,  pending_d;
  logic             overrun_q,  overrun_d;
  logic             prev_upd_q, prev_upd_d;
  logic             armed_q,    armed_d;
  logic [15:0][7:0] shift_buf_q;
  logic [15:0][7:0] pend_buf_q;

  logic       upd_evt;
  logic       bit_tc;
  logic       last_char;
  logic       start_string;
  logic       pend_take;
  logic       load_shift;
  logic       load_from_pend;
  logic       load_pend;
  logic [7:0] cur_byte;

  // The first clock after reset only samples update_temp, so an unknown source cannot fire.
  assign upd_evt   = armed_q & (bus.update_temp != prev_upd_q);
  assign bit_tc    = (timer_q == TMR_LAST);
  assign last_char = (char_idx_q == CHAR_LAST);

  // Character 0 is the most significant byte of the captured string.
  always_comb begin
    cur_byte = shift_buf_q[4'(5'd15 - char_idx_q)];
`ifdef TEMP_UART_CRLF_EN
    if (char_idx_q == 5'd16)      cur_byte = 8'h0D;
    else if (char_idx_q == 5'd17) cur_byte = 8'h0A;
`endif
  end

  // NOTE: every always_comb output gets a default first; a path that leaves one unassigned infers a latch.
  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    bit_idx_d      = bit_idx_q;
    char_idx_d     = char_idx_q;
    tx_d           = tx_q;
    pending_d      = pending_q;
    overrun_d      = 1'b0;
    prev_upd_d     = bus.update_temp;
    armed_d        = 1'b1;
    start_string   = 1'b0;
    pend_take      = 1'b0;
    load_shift     = 1'b0;
    load_from_pend = 1'b0;
    load_pend      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pending_q) begin
          start_string = 1'b1;
          pend_take    = 1'b1;
        end else if (upd_evt) begin
          start_string = 1'b1;
        end
      end
      START: begin
        if (bit_tc) begin
          timer_d   = '0;
          bit_idx_d = 3'd0;
          tx_d      = cur_byte[0];
          state_d   = DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_tc) begin
          timer_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = cur_byte[bit_idx_q + 3'd1];
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_tc) begin
          timer_d = '0;
          if (!last_char) begin
            char_idx_d = char_idx_q + 5'd1;
            tx_d       = 1'b0;
            state_d    = START;
          end else if (pending_q) begin
            start_string = 1'b1;
            pend_take    = 1'b1;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Back-to-back strings: the start bit follows the previous stop bit with no idle gap.
    if (start_string) begin
      state_d        = START;
      timer_d        = '0;
      char_idx_d     = 5'd0;
      tx_d           = 1'b0;
      load_shift     = 1'b1;
      load_from_pend = pend_take;
    end

    // An update that cannot start a string right now parks in the pending slot; newest wins.
    if (upd_evt && (state_q != IDLE || pending_q)) begin
      load_pend = 1'b1;
      pending_d = 1'b1;
      overrun_d = pending_q & ~pend_take;
    end else if (pend_take) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bit_idx_q  <= 3'd0;
      char_idx_q <= 5'd0;
      tx_q       <= 1'b1;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      prev_upd_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      char_idx_q <= char_idx_d;
      tx_q       <= tx_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      prev_upd_q <= prev_upd_d;
      armed_q    <= armed_d;
    end
  end

  // NOTE: the string buffers carry no reset; they are only read after a load qualified by reset-cleared state.
  always_ff @(posedge clk) begin
    if (load_shift) shift_buf_q <= load_from_pend ? pend_buf_q : bus.capt_temp;
    if (load_pend)  pend_buf_q  <= bus.capt_temp;
  end

  assign bus.uart_tx = tx_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_temp_uart_tx.sv
// Directed bench for temp_uart_tx: a frame-level waveform model checked every cycle,
// plus a UART decoder and literal expectations for latency, bytes, bit pattern and overrun.
module tb_temp_uart_tx;

  localparam int B = 16;
`ifdef TEMP_UART_CRLF_EN
  localparam int NCH = 18;
`else
  localparam int NCH = 16;
`endif
  localparam int STR_CLKS = NCH * 10 * B;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  temp_uart_if bus ();

  temp_uart_tx #(.BIT_CLKS(B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] char_of(input logic [15:0][7:0] s, input int c);
    if (c < 16)       return s[15 - c];
    else if (c == 16) return 8'h0D;
    else              return 8'h0A;
  endfunction

  // ---------------- behavioural model: per-cycle line levels ----------------
  bit               m_wave[$];
  logic [15:0][7:0] m_pend;
  bit               m_pend_v = 1'b0;
  bit               m_active = 1'b0;
  bit               m_armed  = 1'b0;
  bit               m_prev   = 1'b0;
  bit               m_evt    = 1'b0;
  bit               m_tx     = 1'b1;
  bit               m_busy   = 1'b0;
  bit               m_ovr    = 1'b0;

  task automatic m_start(input logic [15:0][7:0] s);
    for (int c = 0; c < NCH; c++) begin
      logic [7:0] ch;
      ch = char_of(s, c);
      for (int k = 0; k < 10; k++) begin
        bit lvl;
        lvl = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : ch[k-1];
        repeat (B) m_wave.push_back(lvl);
      end
    end
    m_tx     = m_wave.pop_front();
    m_active = 1'b1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wave.delete();
      m_pend_v = 1'b0;
      m_active = 1'b0;
      m_armed  = 1'b0;
      m_prev   = 1'b0;
      m_tx     = 1'b1;
      m_busy   = 1'b0;
      m_ovr    = 1'b0;
    end else begin
      m_evt   = m_armed && (bus.update_temp != m_prev);
      m_prev  = bus.update_temp;
      m_armed = 1'b1;
      m_ovr   = 1'b0;
      if (m_active && m_wave.size() > 0) begin
        m_tx = m_wave.pop_front();
        if (m_evt) begin
          if (m_pend_v) m_ovr = 1'b1;
          m_pend   = bus.capt_temp;
          m_pend_v = 1'b1;
        end
      end else if (m_pend_v) begin
        m_start(m_pend);
        m_pend_v = 1'b0;
        if (m_evt) begin
          m_pend   = bus.capt_temp;
          m_pend_v = 1'b1;
        end
      end else if (m_active) begin
        m_active = 1'b0;
        m_tx     = 1'b1;
        if (m_evt) begin
          m_pend   = bus.capt_temp;
          m_pend_v = 1'b1;
        end
      end else if (m_evt) begin
        m_start(bus.capt_temp);
      end
      m_busy = m_active;
    end
  end

  // Single compare process against the model, away from the active edge.
  always @(negedge clk) begin
    check("tx_vs_model",      int'(bus.uart_tx), int'(m_tx));
    check("busy_vs_model",    int'(bus.busy),    int'(m_busy));
    check("overrun_vs_model", int'(bus.overrun), int'(m_ovr));
  end

  // ---------------- monitors: busy/overrun counts, line trace, UART decoder ----------------
  int         busy_cnt = 0;
  int         ovr_cnt  = 0;
  bit         line_q[$];
  logic [7:0] rx_q[$];
  bit         rx_active = 1'b0;
  int         rx_cnt    = 0;
  logic [7:0] rx_byte   = 8'h00;

  always @(negedge clk) begin
    if (bus.busy) begin
      busy_cnt++;
      line_q.push_back(bus.uart_tx);
    end
    if (bus.overrun) ovr_cnt++;
  end

  always @(negedge clk) begin
    if (!rx_active) begin
      if (rst_n && bus.uart_tx == 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % B == B / 2) begin
        if (rx_cnt / B >= 1 && rx_cnt / B <= 8) begin
          rx_byte[rx_cnt / B - 1] = bus.uart_tx;
        end else if (rx_cnt / B == 9) begin
          rx_q.push_back(rx_byte);
          rx_active = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [15:0][7:0] s1, s2, sa, sb, sc;
  bit               c_pat [10];

  task automatic toggle(input logic [15:0][7:0] s);
    @(posedge clk);
    #1;
    bus.capt_temp   = s;
    bus.update_temp = ~bus.update_temp;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while (bus.busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) check("idle_timeout", 1, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic expect_rx(input int base, input logic [15:0][7:0] s, input string tag);
    for (int c = 0; c < NCH; c++) begin
      if (base + c < rx_q.size()) check(tag, int'(rx_q[base + c]), int'(char_of(s, c)));
      else                        check(tag, -1, int'(char_of(s, c)));
    end
  endtask

  initial begin
    int busy_base, ovr_base, rx_base, line_base, idx0, cnt;

    s1 = "     C 0025.5000";
    s2 = "     F 0077.9000";
    sa = "     A 0001.0000";
    sb = "     B 0002.0000";
    sc = "     C 0003.0000";
    c_pat = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    bus.update_temp = 1'b0;
    bus.capt_temp   = '0;
    rst_n           = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_tx_after_reset",   int'(bus.uart_tx), 1);
    check("idle_busy_after_reset", int'(bus.busy),    0);
    check("idle_no_frames",        rx_q.size(),       0);
    check("idle_no_busy_cycles",   busy_cnt,          0);

    // Single string: latency, duration, bytes, bit pattern of 'C'.
    busy_base = busy_cnt;
    line_base = line_q.size();
    rx_base   = rx_q.size();
    toggle(s1);
    check("no_low_at_toggle", int'(bus.uart_tx), 1);
    @(posedge clk);
    #1;
    check("start_low_1clk",   int'(bus.uart_tx), 0);
    check("busy_high_1clk",   int'(bus.busy),    1);
    wait_idle();
    check("busy_duration", busy_cnt - busy_base, STR_CLKS);
    check("rx_count_s1",   rx_q.size() - rx_base, NCH);
    expect_rx(rx_base, s1, "rx_s1_byte");
    idx0 = line_base + 5 * 10 * B;
    for (int b = 0; b < 10; b++) begin
      cnt = 0;
      for (int c = 0; c < B; c++)
        if (idx0 + b * B + c < line_q.size() && line_q[idx0 + b * B + c] == c_pat[b]) cnt++;
      check("c_bit_held", cnt, B);
    end

    // Second toggle mid-string: queued string follows with no idle gap.
    busy_base = busy_cnt;
    ovr_base  = ovr_cnt;
    rx_base   = rx_q.size();
    toggle(s1);
    repeat (100) @(negedge clk);
    toggle(s2);
    wait_idle();
    check("b2b_busy_continuous", busy_cnt - busy_base, 2 * STR_CLKS);
    check("b2b_no_overrun",      ovr_cnt - ovr_base,   0);
    check("b2b_rx_count",        rx_q.size() - rx_base, 2 * NCH);
    expect_rx(rx_base,       s1, "rx_b2b_first");
    expect_rx(rx_base + NCH, s2, "rx_b2b_second");

    // Three toggles in one transmission: B is overwritten by C.
    busy_base = busy_cnt;
    ovr_base  = ovr_cnt;
    rx_base   = rx_q.size();
    toggle(sa);
    repeat (100) @(negedge clk);
    toggle(sb);
    repeat (100) @(negedge clk);
    toggle(sc);
    wait_idle();
    check("ovr_pulse_once",  ovr_cnt - ovr_base,    1);
    check("ovr_busy_cycles", busy_cnt - busy_base,  2 * STR_CLKS);
    check("ovr_rx_count",    rx_q.size() - rx_base, 2 * NCH);
    expect_rx(rx_base,       sa, "rx_ovr_a");
    expect_rx(rx_base + NCH, sc, "rx_ovr_c");

    // Reset in the middle of a data bit, then a fresh string after re-arming.
    toggle(s1);
    repeat (3 * B + 5) @(posedge clk);
    #1;
    check("pre_reset_busy", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("reset_tx_high",  int'(bus.uart_tx), 1);
    check("reset_busy_low", int'(bus.busy),    0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    busy_base = busy_cnt;
    repeat (200) @(negedge clk);
    check("post_reset_idle_tx",   int'(bus.uart_tx),   1);
    check("post_reset_no_busy",   busy_cnt - busy_base, 0);
    rx_base = rx_q.size();
    toggle(s2);
    wait_idle();
    check("fresh_busy_duration", busy_cnt - busy_base,  STR_CLKS);
    check("fresh_rx_count",      rx_q.size() - rx_base, NCH);
    expect_rx(rx_base, s2, "rx_fresh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule
